exp_brm_banked: RTL and testbench

//  Expansion-port backup-RAM mapper: CD-unit style BRAM window plus 16-byte register window.

---
 rtl/exp_brm_banked_pkg.sv | 20 ++
 rtl/exp_brm_banked_key_fsm.sv | 108 ++++++++++
 rtl/exp_brm_banked.sv | 114 +++++++++++
 tb/tb_exp_brm_banked.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_brm_banked_pkg.sv
// Shared types and constants for the banked backup-RAM mapper:
// write-protect state encoding, register-window offsets and key bytes.
package exp_brm_pkg;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    KEY1   = 2'd1,
    OPEN   = 2'd2
  } brm_wp_t;

  localparam logic [3:0] REG_ON   = 4'h7;
  localparam logic [3:0] REG_OFF  = 4'h3;
  localparam logic [3:0] REG_BANK = 4'h8;
  localparam logic [3:0] REG_STAT = 4'h9;
  localparam logic [3:0] REG_KEY  = 4'hF;

  localparam logic [7:0] KEY_A = 8'h55;
  localparam logic [7:0] KEY_B = 8'hAA;

endpackage

// File: rtl/exp_brm_banked_key_fsm.sv
// Write-protect key-sequence FSM for the backup RAM.
// Key 0x55 then 0xAA (within KEY_TO cycles) opens the RAM for writing.
// Optional feature macro: BRM_AUTOLOCK_EN -- relocks after LOCK_CYC cycles
// without a RAM write while OPEN.
module brm_key_fsm
  import exp_brm_pkg::*;
#(
  parameter int KEY_TO   = 1024,
  parameter int LOCK_CYC = 2**20
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_we,
  input  logic [7:0] key_dat,
  input  logic       force_lock,
  input  logic       wr_act,
  output brm_wp_t    state
);

  localparam int TW = $clog2(KEY_TO + 1);

  brm_wp_t       state_q, state_d;
  logic [TW-1:0] key_tmr_q, key_tmr_d;

`ifdef BRM_AUTOLOCK_EN
  localparam int LW = $clog2(LOCK_CYC + 1);
  logic [LW-1:0] lock_tmr_q, lock_tmr_d;
`else
  logic unused_autolock;
  assign unused_autolock = wr_act | (LOCK_CYC == 0);
`endif

  assign state = state_q;

  // Next-state logic: key sequence, key timeout, optional idle relock; forced lock wins.
  always_comb begin
    state_d   = state_q;
    key_tmr_d = key_tmr_q;
`ifdef BRM_AUTOLOCK_EN
    lock_tmr_d = lock_tmr_q;
`endif
    case (state_q)
      LOCKED: begin
        if (key_we && key_dat == KEY_A) begin
          state_d   = KEY1;
          key_tmr_d = TW'(KEY_TO);
        end
      end
      KEY1: begin
        if (key_we) begin
          state_d = (key_dat == KEY_B) ? OPEN : LOCKED;
        end else if (key_tmr_q == '0) begin
          state_d = LOCKED;
        end else begin
          key_tmr_d = key_tmr_q - TW'(1);
        end
      end
      OPEN: begin
        if (key_we) begin
          state_d = LOCKED;
        end
`ifdef BRM_AUTOLOCK_EN
        else if (wr_act) begin
          lock_tmr_d = LW'(LOCK_CYC);
        end else if (lock_tmr_q == '0) begin
          state_d = LOCKED;
        end else begin
          lock_tmr_d = lock_tmr_q - LW'(1);
        end
`endif
      end
      default: state_d = LOCKED;
    endcase
    if (force_lock) begin
      state_d = LOCKED;
    end
    // Timers only carry meaning in their own state; keep them cleared elsewhere.
    if (state_d != KEY1) begin
      key_tmr_d = '0;
    end
`ifdef BRM_AUTOLOCK_EN
    if (state_d == OPEN && state_q != OPEN) begin
      lock_tmr_d = LW'(LOCK_CYC);
    end
    if (state_d != OPEN) begin
      lock_tmr_d = '0;
    end
`endif
  end

  // State and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOCKED;
      key_tmr_q <= '0;
`ifdef BRM_AUTOLOCK_EN
      lock_tmr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      key_tmr_q <= key_tmr_d;
`ifdef BRM_AUTOLOCK_EN
      lock_tmr_q <= lock_tmr_d;
`endif
    end
  end

endmodule

// File: rtl/exp_brm_banked.sv
// Expansion-port backup-RAM mapper: banked BRAM window plus a 16-byte
// register window (enable, disable, bank select, status, key port).
// Optional feature macro: BRM_AUTOLOCK_EN (idle auto-relock in brm_key_fsm).
module exp_brm_banked
  import exp_brm_pkg::*;
#(
  parameter int          SIZE_LOG2 = 11,
  parameter int          NBANKS    = 4,
  parameter logic [20:0] RAM_BASE  = 21'h1EE000,
  parameter logic [20:0] REG_BASE  = 21'h1FF800,
  parameter int          KEY_TO    = 1024,
  parameter int          LOCK_CYC  = 2**20,
  localparam int         BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    map_rst,
  input  logic                    cpu_rst,
  input  logic [20:0]             cpu_addr,
  input  logic [7:0]              cpu_dati,
  input  logic                    cpu_oe,
  input  logic                    cpu_we,
  input  logic                    cpu_oe_sync,
  input  logic                    cpu_we_sync,
  input  logic [7:0]              brm_dato,
  output logic [SIZE_LOG2+BW-1:0] brm_addr,
  output logic [7:0]              brm_dati,
  output logic                    brm_ce,
  output logic                    brm_oe,
  output logic                    brm_we,
  output logic                    exp_ce,
  output logic [7:0]              exp_dato
);

  // Bank writes wrap modulo NBANKS (all-zero mask for a single bank).
  localparam logic [BW-1:0] BANK_MASK = BW'(NBANKS - 1);

  logic          ram_on_q, ram_on_d;
  logic [BW-1:0] bank_q, bank_d;
  brm_wp_t       wp_state;
  logic [1:0]    wp_code;
  logic          ram_hit, reg_hit;
  logic [3:0]    reg_off;
  logic          reg_wr, reg_rd, stat_rd;
  logic          key_we, wr_act, force_lock;
  logic [7:0]    status;

  assign ram_hit = (cpu_addr[20:SIZE_LOG2] == RAM_BASE[20:SIZE_LOG2]);
  assign reg_hit = (cpu_addr[20:4] == REG_BASE[20:4]);
  assign reg_off = cpu_addr[3:0];
  assign reg_wr  = reg_hit & cpu_we_sync;
  assign reg_rd  = reg_hit & cpu_oe_sync;
  assign key_we  = reg_wr & (reg_off == REG_KEY);
  assign stat_rd = reg_hit & (reg_off == REG_STAT) & cpu_oe;

  // Register-window updates; either synchronous reset returns everything to idle.
  always_comb begin
    ram_on_d = ram_on_q;
    bank_d   = bank_q;
    if (reg_wr && reg_off == REG_ON) begin
      ram_on_d = cpu_dati[7];
    end
    if (reg_rd && reg_off == REG_OFF) begin
      ram_on_d = 1'b0;
    end
    if (reg_wr && reg_off == REG_BANK) begin
      bank_d = cpu_dati[BW-1:0] & BANK_MASK;
    end
    if (map_rst || cpu_rst) begin
      ram_on_d = 1'b0;
      bank_d   = '0;
    end
  end

  // Enable and bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_on_q <= 1'b0;
      bank_q   <= '0;
    end else begin
      ram_on_q <= ram_on_d;
      bank_q   <= bank_d;
    end
  end

  // A cleared enable (now or in the coming cycle) and the sync resets all relock.
  assign force_lock = ~ram_on_d;
  assign wr_act     = brm_ce & cpu_we_sync;

  brm_key_fsm #(
    .KEY_TO   (KEY_TO),
    .LOCK_CYC (LOCK_CYC)
  ) u_key_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_we     (key_we),
    .key_dat    (cpu_dati),
    .force_lock (force_lock),
    .wr_act     (wr_act),
    .state      (wp_state)
  );

  assign wp_code  = wp_state;
  assign status   = {ram_on_q, wp_code, 2'b00, 3'(bank_q)};

  assign brm_addr = {bank_q, cpu_addr[SIZE_LOG2-1:0]};
  assign brm_dati = cpu_dati;
  assign brm_oe   = cpu_oe;
  assign brm_ce   = ram_hit & ram_on_q;
  assign brm_we   = cpu_we & (wp_state == OPEN);
  assign exp_ce   = brm_ce | stat_rd;
  assign exp_dato = stat_rd ? status : brm_dato;

endmodule

// File: tb/tb_exp_brm_banked.sv
// Bench for exp_brm_banked: timestamp-based reference model plus directed
// vectors with literal expectations. Honours BRM_AUTOLOCK_EN if defined.
module tb_exp_brm_banked;

  localparam int          KEY_TO   = 64;
  localparam int          LOCK_CYC = 100;
  localparam int          NBANKS   = 4;
  localparam logic [20:0] RAM_BASE = 21'h1EE000;
  localparam logic [20:0] REG_BASE = 21'h1FF800;

  logic        clk = 1'b0;
  logic        rst_n, map_rst, cpu_rst;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_dati, brm_dato;
  logic        cpu_oe, cpu_we, cpu_oe_sync, cpu_we_sync;
  logic [12:0] brm_addr;
  logic [7:0]  brm_dati, exp_dato;
  logic        brm_ce, brm_oe, brm_we, exp_ce;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // model state
  int m_on = 0, m_bank = 0, m_state = 0;
  int cyc = 0, t_key = 0, t_act = 0;

  always #5 clk = ~clk;

  exp_brm_banked #(
    .SIZE_LOG2 (11),
    .NBANKS    (NBANKS),
    .RAM_BASE  (RAM_BASE),
    .REG_BASE  (REG_BASE),
    .KEY_TO    (KEY_TO),
    .LOCK_CYC  (LOCK_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .map_rst     (map_rst),
    .cpu_rst     (cpu_rst),
    .cpu_addr    (cpu_addr),
    .cpu_dati    (cpu_dati),
    .cpu_oe      (cpu_oe),
    .cpu_we      (cpu_we),
    .cpu_oe_sync (cpu_oe_sync),
    .cpu_we_sync (cpu_we_sync),
    .brm_dato    (brm_dato),
    .brm_addr    (brm_addr),
    .brm_dati    (brm_dati),
    .brm_ce      (brm_ce),
    .brm_oe      (brm_oe),
    .brm_we      (brm_we),
    .exp_ce      (exp_ce),
    .exp_dato    (exp_dato)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ram_hit_f(input logic [20:0] a);
    return (a >> 11) == (RAM_BASE >> 11);
  endfunction

  function automatic bit reg_hit_f(input logic [20:0] a);
    return (a >> 4) == (REG_BASE >> 4);
  endfunction

  // One clock edge of the reference model, from the bus as seen at the edge.
  task automatic model_step();
    int off;
    int new_on;
    bit wr, rd, key;
    off    = int'(cpu_addr) % 16;
    wr     = reg_hit_f(cpu_addr) && cpu_we_sync;
    rd     = reg_hit_f(cpu_addr) && cpu_oe_sync;
    key    = wr && off == 15;
    new_on = m_on;
    if (wr && off == 7) new_on = int'(cpu_dati) / 128;
    if (rd && off == 3) new_on = 0;
    if (wr && off == 8) m_bank = int'(cpu_dati) % NBANKS;
    if (new_on == 0) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (key && cpu_dati == 8'h55) begin
             m_state = 1;
             t_key   = cyc;
           end
        1: begin
             if (key) begin
               if (cpu_dati == 8'hAA) begin
                 m_state = 2;
                 t_act   = cyc;
               end else begin
                 m_state = 0;
               end
             end else if (cyc - t_key > KEY_TO) begin
               m_state = 0;
             end
           end
        default: begin
             if (key) m_state = 0;
`ifdef BRM_AUTOLOCK_EN
             else if (ram_hit_f(cpu_addr) && m_on != 0 && cpu_we_sync) t_act = cyc;
             else if (cyc - t_act > LOCK_CYC) m_state = 0;
`endif
           end
      endcase
    end
    m_on = new_on;
  endtask

  // Model update process.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || map_rst || cpu_rst) begin
        m_on    = 0;
        m_bank  = 0;
        m_state = 0;
      end else begin
        model_step();
      end
      cyc++;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    int  e_stat, e_addr;
    bit  e_ce, e_srd, e_we;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_ce   = ram_hit_f(cpu_addr) && m_on != 0;
        e_srd  = reg_hit_f(cpu_addr) && (int'(cpu_addr) % 16 == 9) && cpu_oe;
        e_we   = cpu_we && m_state == 2;
        e_stat = m_on * 128 + m_state * 32 + m_bank;
        e_addr = m_bank * 2048 + int'(cpu_addr) % 2048;
        chk("m_brm_addr", 32'(brm_addr), 32'(e_addr));
        chk("m_brm_dati", 32'(brm_dati), 32'(cpu_dati));
        chk("m_brm_oe",   32'(brm_oe),   32'(cpu_oe));
        chk("m_brm_ce",   32'(brm_ce),   32'(e_ce));
        chk("m_brm_we",   32'(brm_we),   32'(e_we));
        chk("m_exp_ce",   32'(exp_ce),   32'(e_ce || e_srd));
        chk("m_exp_dato", 32'(exp_dato), e_srd ? 32'(e_stat) : 32'(brm_dato));
      end
    end
  end

  task automatic set_bus(input logic [20:0] a, input logic [7:0] d,
                         input logic oe, input logic we, input logic oes, input logic wes);
    cpu_addr    = a;
    cpu_dati    = d;
    cpu_oe      = oe;
    cpu_we      = we;
    cpu_oe_sync = oes;
    cpu_we_sync = wes;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cpu_oe_sync = 1'b0;
    cpu_we_sync = 1'b0;
    brm_dato    = 8'($urandom);
  endtask

  task automatic idle(input int n);
    set_bus(21'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic reg_write(input logic [3:0] off, input logic [7:0] d);
    set_bus(REG_BASE | 21'(off), d, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    set_bus(21'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_stat(input string nm, input logic [7:0] want);
    set_bus(REG_BASE | 21'h9, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk(nm, 32'(exp_dato), 32'(want));
    tick();
    set_bus(21'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic open_ram();
    reg_write(4'h7, 8'h80);
    reg_write(4'hF, 8'h55);
    reg_write(4'hF, 8'hAA);
  endtask

  initial begin
    rst_n = 1'b0; map_rst = 1'b0; cpu_rst = 1'b0; brm_dato = 8'h3C;
    // Reset with a RAM write pending on the bus.
    set_bus(21'h1EE005, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_en = 1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_brm_ce", 32'(brm_ce), 32'd0);
    chk("rst_brm_we", 32'(brm_we), 32'd0);
    chk("rst_exp_ce", 32'(exp_ce), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: enable, read and write the RAM window while locked.
    reg_write(4'h7, 8'h80);
    set_bus(21'h1EE005, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_brm_ce", 32'(brm_ce), 32'd1);
    chk("t1_brm_addr", 32'(brm_addr), 32'h005);
    chk("t1_exp_dato", 32'(exp_dato), 32'(brm_dato));
    tick();
    set_bus(21'h1EE005, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_brm_we_locked", 32'(brm_we), 32'd0);
    tick();

    // 2: key sequence opens writes.
    reg_write(4'hF, 8'h55);
    idle(3);
    reg_write(4'hF, 8'hAA);
    rd_stat("t2_status_open", 8'hC0);
    set_bus(21'h1EE010, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_brm_we_open", 32'(brm_we), 32'd1);
    tick();

    // 3: relock, then let the key window expire.
    reg_write(4'hF, 8'h00);
    reg_write(4'hF, 8'h55);
    idle(KEY_TO + 1);
    reg_write(4'hF, 8'hAA);
    rd_stat("t3_status_timeout", 8'h80);
    set_bus(21'h1EE010, 8'h12, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_brm_we_locked", 32'(brm_we), 32'd0);
    tick();
    // Second key on the last allowed cycle still opens.
    reg_write(4'hF, 8'h55);
    idle(KEY_TO - 1);
    reg_write(4'hF, 8'hAA);
    rd_stat("t3_status_edge", 8'hC0);

    // 4: bank select and wrap.
    reg_write(4'h8, 8'h06);
    set_bus(21'h1EE7FF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_brm_addr", 32'(brm_addr), 32'h17FF);
    tick();
    rd_stat("t4_status_bank2", 8'hC2);
    reg_write(4'h8, 8'hFF);
    rd_stat("t4_status_bank3", 8'hC3);

    // 5: legacy disable read, then async reset mid-write.
    set_bus(REG_BASE | 21'h3, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_off_no_drive", 32'(exp_ce), 32'd0);
    tick();
    rd_stat("t5_status_off", 8'h03);
    set_bus(21'h1EE010, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_brm_ce_off", 32'(brm_ce), 32'd0);
    tick();
    open_ram();
    set_bus(21'h1EE010, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("t5_we_before_rst", 32'(brm_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_we_cut_async", 32'(brm_we), 32'd0);
    tick();
    rst_n = 1'b1;
    rd_stat("t5_status_after_rst", 8'h00);
    // Synchronous resets.
    open_ram();
    map_rst = 1'b1;
    tick();
    map_rst = 1'b0;
    rd_stat("t5_status_map_rst", 8'h00);
    open_ram();
    cpu_rst = 1'b1;
    set_bus(REG_BASE | 21'hF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    cpu_rst = 1'b0;
    rd_stat("t5_status_cpu_rst", 8'h00);

    // 6: idle after one write while OPEN.
    open_ram();
    set_bus(21'h1EE010, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle(LOCK_CYC + 1);
`ifdef BRM_AUTOLOCK_EN
    rd_stat("t6_status_autolock", 8'h80);
`else
    rd_stat("t6_status_still_open", 8'hC0);
`endif
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
